// File: rtl/task_cmd_pkg.sv
// Shared types for the task command arbiter: opcodes, controller states and
// the per-opcode result mask.
package task_cmd_pkg;

   typedef enum logic [1:0] {
      OP_T1 = 2'd0,
      OP_T2 = 2'd1,
      OP_T3 = 2'd2,
      OP_T4 = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   // Only the bits a task actually produces are passed back to the requester.
   function automatic logic [1:0] mask_result(input op_e op, input logic [1:0] res);
      logic [1:0] m;
      case (op)
         OP_T3:   m = {1'b0, res[0]};
         OP_T4:   m = res;
         default: m = 2'b00;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/task_cmd_arbiter_rr.sv
// Combinational round-robin pick: first requester above last, wrapping around.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]          req,
   input  logic [$clog2(N)-1:0]  last,
   output logic [N-1:0]          grant,
   output logic [$clog2(N)-1:0]  idx,
   output logic                  any
);

   localparam int IW = $clog2(N);

   always_comb begin
      int             pos;
      logic [IW-1:0]  p;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = 0;
      p     = '0;
      for (int k = 1; k <= N; k++) begin
         pos = (int'(last) + k) % N;
         p   = IW'(pos);
         if (!any && req[p]) begin
            any      = 1'b1;
            grant[p] = 1'b1;
            idx      = p;
         end
      end
   end

endmodule

// File: rtl/task_cmd_arbiter.sv
// Shares one task executor among NREQ requesters: round-robin grant, a single
// outstanding command, executor timeout and result routed back to the winner.
module task_cmd_arbiter
   import task_cmd_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64,
   parameter int CNTW    = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [2*NREQ-1:0]        req_op,
   input  logic [NREQ-1:0]          req_arg,
   output logic                     exe_valid,
   input  logic                     exe_ready,
   output logic [1:0]               exe_op,
   output logic                     exe_arg,
   input  logic                     exe_done,
   input  logic [1:0]               exe_result,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [1:0]               rsp_result,
   output logic                     rsp_err,
   output logic [CNTW-1:0]          cmd_cnt
);

   localparam int IW = $clog2(NREQ);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] ST_IDLE  = 2'(IDLE);
   localparam logic [1:0] ST_ISSUE = 2'(ISSUE);
   localparam logic [1:0] ST_WAIT  = 2'(WAIT);
   localparam logic [1:0] ST_RESP  = 2'(RESP);

   logic [1:0]       state_reg;
   logic [IW-1:0]    last_grant_reg;
   logic [IW-1:0]    id_reg;
   logic [1:0]       op_reg;
   logic             arg_reg;
   logic [1:0]       result_reg;
   logic             err_reg;
   logic             exe_valid_reg;
   logic             rsp_valid_reg;
   logic [TW-1:0]    wait_cnt_reg;
   logic [CNTW-1:0]  cmd_cnt_reg;

   logic [NREQ-1:0]  grant;
   logic [IW-1:0]    grant_idx;
   logic             grant_any;
   logic             timeout_hit;
   logic [1:0]       op_arr [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_op_slice
      assign op_arr[gi] = req_op[2*gi +: 2];
   end

   rr_arbiter #(.N(NREQ)) u_rr (
      .req   (req_valid),
      .last  (last_grant_reg),
      .grant (grant),
      .idx   (grant_idx),
      .any   (grant_any)
   );

   // Accept is the only combinational output so a requester sees its grant in the same cycle.
   assign req_ready   = (state_reg == ST_IDLE) ? grant : '0;
   assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_reg == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         last_grant_reg <= IW'(NREQ - 1);
         id_reg         <= '0;
         op_reg         <= '0;
         arg_reg        <= 1'b0;
         result_reg     <= '0;
         err_reg        <= 1'b0;
         exe_valid_reg  <= 1'b0;
         rsp_valid_reg  <= 1'b0;
         wait_cnt_reg   <= '0;
         cmd_cnt_reg    <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (grant_any) begin
                  op_reg        <= op_arr[grant_idx];
                  arg_reg       <= req_arg[grant_idx];
                  id_reg        <= grant_idx;
                  cmd_cnt_reg   <= cmd_cnt_reg + 1'b1;
                  exe_valid_reg <= 1'b1;
                  state_reg     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (exe_ready) begin
                  exe_valid_reg <= 1'b0;
                  wait_cnt_reg  <= '0;
                  state_reg     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // A completion in the final allowed cycle beats the timeout.
               if (exe_done) begin
                  result_reg    <= mask_result(op_e'(op_reg), exe_result);
                  err_reg       <= 1'b0;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= ST_RESP;
               end else if (timeout_hit) begin
                  result_reg    <= 2'b00;
                  err_reg       <= 1'b1;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= ST_RESP;
               end else begin
                  wait_cnt_reg  <= wait_cnt_reg + 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_reg  <= 1'b0;
                  last_grant_reg <= id_reg;
                  state_reg      <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign exe_valid  = exe_valid_reg;
   assign exe_op     = op_reg;
   assign exe_arg    = arg_reg;
   assign rsp_valid  = rsp_valid_reg;
   assign rsp_id     = id_reg;
   assign rsp_result = result_reg;
   assign rsp_err    = err_reg;
   assign cmd_cnt    = cmd_cnt_reg;

endmodule

// File: tb/tb_task_cmd_arbiter.sv
// Directed bench for task_cmd_arbiter: a transaction-level model checked every
// cycle, plus literal expectations for latency, grant order, masking and timeout.
module tb_task_cmd_arbiter;
   import task_cmd_pkg::*;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 64;
   localparam int CNTW    = 16;
   localparam int IW      = 2;

   logic                clk = 1'b0;
   logic                rst_n = 1'b1;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ-1:0]     req_ready;
   logic [2*NREQ-1:0]   req_op = '0;
   logic [NREQ-1:0]     req_arg = '0;
   logic                exe_valid;
   logic                exe_ready = 1'b1;
   logic [1:0]          exe_op;
   logic                exe_arg;
   logic                exe_done = 1'b0;
   logic [1:0]          exe_result = 2'b00;
   logic                rsp_valid;
   logic                rsp_ready = 1'b1;
   logic [IW-1:0]       rsp_id;
   logic [1:0]          rsp_result;
   logic                rsp_err;
   logic [CNTW-1:0]     cmd_cnt;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int done_delay = 1;
   logic [1:0] done_value = 2'b00;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task_cmd_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_arg    (req_arg),
      .exe_valid  (exe_valid),
      .exe_ready  (exe_ready),
      .exe_op     (exe_op),
      .exe_arg    (exe_arg),
      .exe_done   (exe_done),
      .exe_result (exe_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err),
      .cmd_cnt    (cmd_cnt)
   );

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit bitof(input logic [NREQ-1:0] v, input int j);
      return ((v >> j) & NREQ'(1)) != '0;
   endfunction

   // Round-robin rule: first valid requester after the previous winner, wrapping.
   function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++)
         if (bitof(v, (last + k) % NREQ)) return (last + k) % NREQ;
      return -1;
   endfunction

   function automatic int masked(input int op, input int r);
      if (op == 2) return r % 2;
      if (op == 3) return r;
      return 0;
   endfunction

   // Transaction-level model: one command in flight, tracked through its phases.
   bit m_busy = 0, m_issue = 0, m_wait = 0, m_resp = 0;
   int m_last = NREQ - 1, m_count = 0, m_wcnt = 0;
   int m_id = 0, m_op = 0, m_arg = 0, m_res = 0, m_err = 0;

   always @(negedge clk) begin
      int pick;
      logic [NREQ-1:0] exp_ready;
      if (!rst_n) begin
         chk("rst_req_ready", int'(req_ready), 0);
         chk("rst_exe_valid", int'(exe_valid), 0);
         chk("rst_rsp_valid", int'(rsp_valid), 0);
         chk("rst_cmd_cnt", int'(cmd_cnt), 0);
         m_busy = 0; m_issue = 0; m_wait = 0; m_resp = 0;
         m_last = NREQ - 1; m_count = 0; m_wcnt = 0;
      end else begin
         pick = m_busy ? -1 : rr_pick(req_valid, m_last);
         exp_ready = (pick < 0) ? '0 : (NREQ'(1) << pick);
         chk("req_ready", int'(req_ready), int'(exp_ready));
         chk("exe_valid", int'(exe_valid), int'(m_issue));
         if (m_issue) begin
            chk("exe_op", int'(exe_op), m_op);
            chk("exe_arg", int'(exe_arg), m_arg);
         end
         chk("rsp_valid", int'(rsp_valid), int'(m_resp));
         if (m_resp) begin
            chk("rsp_id", int'(rsp_id), m_id);
            chk("rsp_result", int'(rsp_result), m_res);
            chk("rsp_err", int'(rsp_err), m_err);
         end
         chk("cmd_cnt", int'(cmd_cnt), m_count % (1 << CNTW));

         if (m_resp && rsp_ready) begin
            $display("RESP   id=%0d result=%0d err=%0d cycle=%0d", m_id, m_res, m_err, cyc);
            m_resp = 0; m_busy = 0; m_last = m_id;
         end
         if (m_wait) begin
            if (exe_done) begin
               m_wait = 0; m_resp = 1; m_err = 0;
               m_res = masked(m_op, int'(exe_result));
            end else if (TIMEOUT != 0 && m_wcnt == TIMEOUT - 1) begin
               m_wait = 0; m_resp = 1; m_err = 1; m_res = 0;
            end else begin
               m_wcnt++;
            end
         end
         if (m_issue && exe_ready) begin
            m_issue = 0; m_wait = 1; m_wcnt = 0;
         end
         if (pick >= 0) begin
            m_busy = 1; m_issue = 1; m_id = pick; m_count++;
            m_op  = int'((req_op >> (2 * pick)) & (2*NREQ)'(3));
            m_arg = int'(bitof(req_arg, pick));
            $display("ACCEPT id=%0d op=%0d arg=%0d count=%0d cycle=%0d", m_id, m_op, m_arg, m_count, cyc);
         end
      end
   end

   // Executor stand-in: always ready, pulses done done_delay cycles after the handshake (0 = never).
   initial begin
      int cd;
      cd = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) cd = 0;
         else if (exe_valid && exe_ready) cd = done_delay;
         @(posedge clk); #1;
         exe_done = 1'b0;
         if (cd == 1) begin
            exe_done   = 1'b1;
            exe_result = done_value;
         end
         if (cd > 0) cd--;
      end
   end

   task automatic set_req(input int id, input int op, input bit a);
      req_valid = req_valid | (NREQ'(1) << id);
      req_op    = (req_op & ~((2*NREQ)'(3) << (2 * id))) | ((2*NREQ)'(op) << (2 * id));
      req_arg   = (req_arg & ~(NREQ'(1) << id)) | (NREQ'(a) << id);
   endtask

   task automatic send(input int id, input int op, input bit a, output int acc_cyc);
      bit got;
      got = 0;
      acc_cyc = -1;
      set_req(id, op, a);
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk);
         if (bitof(req_ready, id)) begin
            got = 1;
            acc_cyc = cyc;
         end
         @(posedge clk); #1;
      end
      req_valid = req_valid & ~(NREQ'(1) << id);
      chk("send_accepted", int'(got), 1);
   endtask

   task automatic wait_rsp(input int maxc, output int rc, output int res, output int err, output int id);
      bit got;
      got = 0;
      rc = -1; res = -1; err = -1; id = -1;
      for (int n = 0; n < maxc && !got; n++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            got = 1;
            rc  = cyc;
            res = int'(rsp_result);
            err = int'(rsp_err);
            id  = int'(rsp_id);
         end
         @(posedge clk); #1;
      end
      chk("rsp_seen", int'(got), 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ac, ac2, rc, res, err, id, held, rdy_seen, first, stale;
      bit got;
      int exp_g[5] = '{0, 1, 2, 3, 0};

      #2;
      do_reset();

      // 1: T1 from requester 0, immediate executor -> response 3 cycles after accept
      done_delay = 1; done_value = 2'b11;
      send(0, 0, 1'b0, ac);
      wait_rsp(20, rc, res, err, id);
      chk("t1_latency", rc - ac, 3);
      chk("t1_id", id, 0);
      chk("t1_result", res, 0);
      chk("t1_err", err, 0);

      // 2: result masking for T4 and T3
      done_value = 2'b10;
      send(1, 3, 1'b1, ac);
      wait_rsp(20, rc, res, err, id);
      chk("t2_t4_id", id, 1);
      chk("t2_t4_result", res, 2);
      done_value = 2'b11;
      send(2, 2, 1'b0, ac);
      wait_rsp(20, rc, res, err, id);
      chk("t2_t3_result", res, 1);

      // 3: all requesters continuously valid from reset -> 0,1,2,3,0
      do_reset();
      done_delay = 1;
      req_op = 8'h55; req_arg = 4'b1010; req_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         got = 0; first = -1;
         for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req_ready != '0) begin
               got = 1;
               for (int j = 0; j < NREQ; j++) if (bitof(req_ready, j)) first = j;
            end
            @(posedge clk); #1;
         end
         if (k == 4) req_valid = '0;
         chk("t3_grant", first, exp_g[k]);
      end
      @(negedge clk);
      chk("t3_cmd_cnt", int'(cmd_cnt), 5);
      @(posedge clk); #1;
      wait_rsp(20, rc, res, err, id);
      chk("t3_last_id", id, 0);

      // 4: executor never completes -> timeout error after 64 WAIT cycles
      done_delay = 0;
      send(3, 3, 1'b1, ac);
      wait_rsp(120, rc, res, err, id);
      chk("t4_latency", rc - ac, 66);
      chk("t4_err", err, 1);
      chk("t4_result", res, 0);
      chk("t4_id", id, 3);

      // 5: response back-pressure holds the response and blocks new grants
      done_delay = 1; done_value = 2'b01;
      rsp_ready = 1'b0;
      send(0, 2, 1'b1, ac);
      set_req(1, 3, 1'b0);
      got = 0;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk);
         if (rsp_valid) got = 1;
         @(posedge clk); #1;
      end
      chk("t5_rsp_up", int'(got), 1);
      held = 0; rdy_seen = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (rsp_valid) held++;
         if (req_ready != '0) rdy_seen++;
         @(posedge clk); #1;
      end
      chk("t5_held", held, 10);
      chk("t5_no_ready", rdy_seen, 0);
      rsp_ready = 1'b1;
      wait_rsp(5, rc, res, err, id);
      chk("t5_result", res, 1);
      send(1, 3, 1'b0, ac2);
      chk("t5_next_accept", ac2 - rc, 1);
      wait_rsp(20, rc, res, err, id);
      chk("t5_next_id", id, 1);

      // 6: reset during WAIT abandons the command
      done_delay = 0;
      send(2, 3, 1'b1, ac);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("t6_exe_op", int'(exe_op), 0);
      chk("t6_exe_arg", int'(exe_arg), 0);
      chk("t6_rsp_id", int'(rsp_id), 0);
      chk("t6_cmd_cnt", int'(cmd_cnt), 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      done_delay = 1; done_value = 2'b11;
      set_req(0, 3, 1'b1);
      set_req(2, 2, 1'b1);
      got = 0; first = -1; stale = 0;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk);
         if (rsp_valid) stale++;
         if (req_ready != '0) begin
            got = 1;
            for (int j = 0; j < NREQ; j++) if (bitof(req_ready, j)) first = j;
         end
         @(posedge clk); #1;
      end
      req_valid = req_valid & ~NREQ'(1);
      chk("t6_first_winner", first, 0);
      chk("t6_no_stale_rsp", stale, 0);
      wait_rsp(20, rc, res, err, id);
      chk("t6_rsp_id0", id, 0);
      chk("t6_rsp_res0", res, 3);
      send(2, 2, 1'b1, ac);
      wait_rsp(20, rc, res, err, id);
      chk("t6_rsp_id2", id, 2);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
